// File: rtl/char_buffer_writer_pkg.sv
// Shared constants for the character buffer writer.
//   clog2_min1 : address/counter width helper (ceil(log2(n)), minimum 1 bit)
//   ST_*       : FSM state encoding (CLEAR -> PACE <-> WRITE)
package char_buffer_writer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_CLEAR = 2'd0;
    localparam state_t ST_PACE  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;

    // Bits needed to hold values 0..value-1; never less than one bit so
    // degenerate sizes (value <= 2) still give legal vectors.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/char_buffer_writer_if.sv
// Write port from the character buffer writer to the character RAM arbiter.
//   wr_en    : write request (master -> slave)
//   wr_addr  : linear cell address (master -> slave)
//   wr_data  : character code (master -> slave)
//   wr_ready : arbiter accepts the write this cycle (slave -> master)
interface char_buffer_writer_if #(
    parameter int char_width = 8,
    parameter int addr_width = 13
);
    logic                  wr_en;
    logic [addr_width-1:0] wr_addr;
    logic [char_width-1:0] wr_data;
    logic                  wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/char_buffer_writer_pace_counter.sv
// Pacing counter for the character buffer writer.
//   clk, reset : clock and synchronous active-high reset
//   run        : count this cycle (writer is pacing and enable is high)
//   tick       : high in the cycle the count sits at pace_cycles-1 while
//                running; the count wraps to 0 on that edge
// When run is low the count holds, so a paused interval resumes where it
// stopped rather than restarting.
module char_buffer_writer_pace_counter
    import char_buffer_writer_pkg::*;
#(
    parameter int pace_cycles = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int cnt_w = clog2_min1(pace_cycles);
    localparam logic [cnt_w-1:0] term_cnt = cnt_w'(pace_cycles - 1);

    logic [cnt_w-1:0] cnt_q;
    logic [cnt_w-1:0] cnt_d;

    assign tick = run && (cnt_q == term_cnt);

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/char_buffer_writer.sv
// Character buffer writer: clears the text RAM with clear_char after reset,
// then writes one generator character every pace_cycles enabled cycles at a
// linearly advancing cursor that wraps at the end of the screen.
//   clk, reset : clock and synchronous active-high reset
//   enable     : lets pacing advance (ignored while clearing or writing)
//   c_in       : character from the generator, sampled at the pace tick
//   wr_bus     : write request/ready port to the character RAM arbiter
//   clear_done : sticky, high once the clear pass has completed
//   frame_done : one-cycle pulse after the last cell of a screen is written
module char_buffer_writer
    import char_buffer_writer_pkg::*;
#(
    parameter int                    char_width  = 8,
    parameter int                    cols        = 128,
    parameter int                    rows        = 48,
    parameter int                    pace_cycles = 1000,
    parameter logic [char_width-1:0] clear_char  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [char_width-1:0] c_in,
    char_buffer_writer_if.master  wr_bus,
    output logic                  clear_done,
    output logic                  frame_done
);
    localparam int cells  = cols * rows;
    localparam int addr_w = clog2_min1(cells);
    localparam logic [addr_w-1:0] last_cell = addr_w'(cells - 1);

    state_t                state_q, state_d;
    logic [addr_w-1:0]     cursor_q, cursor_d;
    logic                  wr_en_q, wr_en_d;
    logic [char_width-1:0] wr_data_q, wr_data_d;
    logic                  clear_done_q, clear_done_d;
    logic                  frame_done_q, frame_done_d;

    logic              accept;
    logic              at_last;
    logic [addr_w-1:0] cursor_next;
    logic              pace_run;
    logic              pace_tick;

    assign accept      = wr_en_q && wr_bus.wr_ready;
    assign at_last     = (cursor_q == last_cell);
    // Compare-and-wrap rather than a natural overflow: cells need not be
    // a power of two.
    assign cursor_next = at_last ? '0 : cursor_q + 1'b1;
    assign pace_run    = (state_q == ST_PACE) && enable;

    char_buffer_writer_pace_counter #(
        .pace_cycles (pace_cycles)
    ) u_pace (
        .clk   (clk),
        .reset (reset),
        .run   (pace_run),
        .tick  (pace_tick)
    );

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        wr_en_d      = wr_en_q;
        wr_data_d    = wr_data_q;
        clear_done_d = clear_done_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_data_d = clear_char;
                if (accept) begin
                    cursor_d = cursor_next;
                    if (at_last) begin
                        // Clear pass finished: no frame_done for this lap.
                        wr_en_d      = 1'b0;
                        clear_done_d = 1'b1;
                        state_d      = ST_PACE;
                    end
                end
            end
            ST_PACE: begin
                wr_en_d = 1'b0;
                if (pace_tick) begin
                    wr_data_d = c_in;
                    wr_en_d   = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address and data hold until the arbiter takes the write.
                if (accept) begin
                    cursor_d     = cursor_next;
                    wr_en_d      = 1'b0;
                    frame_done_d = at_last;
                    state_d      = ST_PACE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            cursor_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            clear_done_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            clear_done_q <= clear_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The cursor only moves on an accept, so it doubles as the registered
    // write address and is stable for the whole life of a request.
    assign wr_bus.wr_en   = wr_en_q;
    assign wr_bus.wr_addr = cursor_q;
    assign wr_bus.wr_data = wr_data_q;
    assign clear_done     = clear_done_q;
    assign frame_done     = frame_done_q;
endmodule

// File: doc/char_buffer_writer.md
Name: char_buffer_writer

Overview:
Downstream consumer of the random character generator in the XGA text path. It samples one character per paced interval and writes it into the text-mode character RAM at a linearly advancing cursor, wrapping at end of screen. On reset it first clears the whole buffer with a fill character. Its write port feeds the character RAM arbiter, which may stall it while the display scan-out has priority.

Parameters:
char_width, 8, width of one character code, matching the generator output.
cols, 128, text columns per screen (1024 px / 8 px cell).
rows, 48, text rows per screen (768 px / 16 px cell).
pace_cycles, 1000, clock cycles spent in PACE before each character write; legal range is 1 or more.
clear_char, 0, character code written during the clear pass.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  allows pacing to advance; when low, pacing freezes
c_in  in  char_width  character from the generator
wr_ready  in  1  arbiter accepts the write this cycle
wr_en  out  1  write request
wr_addr  out  log2(cols*rows)  linear cell address, row*cols+col
wr_data  out  char_width  character to write
clear_done  out  1  sticky; high once the clear pass completes
frame_done  out  1  one-cycle pulse after the last cell of a screen is written

Behaviour:
- All outputs and state are registered. Reset is synchronous and active-high on clk; it wins over every other input.
- Reset values: state=CLEAR, cursor=0, pace_cnt=0, wr_en=0, wr_addr=0, wr_data=0, clear_done=0, frame_done=0.
- A write is accepted on any edge where wr_en and wr_ready are both high. While wr_en=1 and wr_ready=0, wr_addr and wr_data are held stable.
- Cursor is a linear counter from 0 to cols*rows-1. It is not a {row,col} concatenation, because cols*rows need not be a power of two. Advancing from cols*rows-1 wraps the cursor to 0.
- CLEAR:
  - wr_en=1, wr_data=clear_char, wr_addr=cursor, starting at the first edge after reset deasserts.
  - Each accept advances the cursor.
  - On accept of the last cell: cursor becomes 0, clear_done becomes 1 on the next cycle, and state goes to PACE. frame_done is not pulsed for the clear pass.
- PACE:
  - wr_en=0.
  - If enable=1, pace_cnt increments. When pace_cnt == pace_cycles-1, c_in is captured into wr_data that cycle, pace_cnt resets to 0, and state goes to WRITE.
  - If enable=0, pace_cnt holds its value.
- WRITE:
  - wr_en=1 and wr_addr=cursor, holding until accepted.
  - c_in is ignored while in WRITE.
  - On accept the cursor advances and state returns to PACE. If the accepted address was cols*rows-1, the cursor wraps to 0 and frame_done=1 for exactly the next cycle.
- enable is ignored in CLEAR and WRITE; a pending write always completes.
- Steady-state period with wr_ready held at 1 is pace_cycles + 1 cycles per character.
- Reset mid-operation abandons any pending write. The next cycle restarts CLEAR at address 0 and clears clear_done.
- cols*rows == 1: every accept wraps. frame_done pulses after every paced write.

Decomposition:
- log2 and the other constant functions come from the shared const_funcs.h. Address width is derived as log2(cols*rows), rounded up for non-powers of two.
- A state encoding include (CLEAR/PACE/WRITE) is kept local.
- Natural sub-module: pace_counter, which takes enable and terminal count pace_cycles-1 and outputs a one-cycle tick.
- The cursor and FSM stay in the top module.

Test Plan:
- cols=4, rows=2, pace_cycles=3, wr_ready=1, release reset -> 8 consecutive writes to addr 0..7 with data 0; clear_done rises the cycle after addr 7; wr_en drops.
- Same setup, enable=1, c_in=8'h41 -> writes of 0x41 to addr 0,1,2,... with wr_en high 1 cycle in every 4 (period 4).
- wr_ready=0 for 5 cycles during WRITE at addr 2, c_in changes to 8'h5A -> wr_en/addr=2/data=0x41 held 6 cycles; accept on wr_ready=1; next write carries 0x5A.
- Run through addr 7 -> frame_done high for exactly the 1 cycle after the addr-7 accept; next write goes to addr 0; clear_done stays 1.
- enable=0 for 10 cycles mid-PACE with pace_cnt=1 -> no wr_en; after enable=1 the write occurs 2 cycles later, not 3.
- Assert reset during WRITE at addr 5 -> addr-5 write is never accepted; clear_done=0; the CLEAR pass restarts at addr 0 with data 0.
